// File: rtl/scramble_sequencer_if.sv
// Command/status bundle between the scramble controller and scramble_sequencer.
// The controller owns start/abort; the sequencer owns every status and move line.
interface scramble_sequencer_if;
  // Handshake: start is a level sampled only in IDLE, and each acceptance begins one run.
  // abort is sampled only in SETUP/FIRE/GAP. All sequencer outputs are registered.
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic       fire;
  logic [3:0] row_column;
  logic       x_nRow;
  logic [7:0] moves_issued;

  modport master (
    output start, abort,
    input  busy, done, fire, row_column, x_nRow, moves_issued
  );

  modport slave (
    input  start, abort,
    output busy, done, fire, row_column, x_nRow, moves_issued
  );
endinterface

// File: rtl/scramble_sequencer.sv
// Pseudo-random row/column fire sequencer that scrambles the 4x4 board.
// A free-running Galois LFSR picks each move, and the FSM paces the fire pulses.
module scramble_sequencer #(
  parameter int unsigned MOVES = 16,
  parameter int unsigned GAP   = 15,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       reset,
  scramble_sequencer_if.slave        bus,
  output logic [2:0]                 o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_FIRE  = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [15:0] LFSR_INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [7:0]  MOVES_L   = 8'(MOVES);
  localparam logic [7:0]  GAP_LAST  = 8'(GAP - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_next;
  logic [7:0]  r_gap_cnt;
  logic [7:0]  r_moves;
  logic        r_busy;
  logic        r_done;
  logic        r_fire;
  logic        r_x_nrow;
  logic [3:0]  r_row_column;
  logic        w_busy_d;
  logic        w_done_d;
  logic        w_fire_d;
  logic        w_cand_x;
  logic [3:0]  w_cand_rc;
  logic [3:0]  w_move_rc;
  logic        w_run_start;
  logic        w_more;

  assign w_lfsr_next = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_MASK : 16'h0000);

  assign w_cand_x  = r_lfsr[2];
  assign w_cand_rc = 4'b0001 << r_lfsr[1:0];

  // The held lines still carry the previous move when the next one is chosen; they are
  // zero when a run starts, so the first move never matches and is never rotated.
  assign w_move_rc = ((w_cand_x == r_x_nrow) && (w_cand_rc == r_row_column)) ?
                     {w_cand_rc[2:0], w_cand_rc[3]} : w_cand_rc;

  assign w_run_start = (r_state == S_IDLE) && bus.start && (MOVES_L != 8'd0);
  assign w_more      = (r_moves < MOVES_L);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next_state = (MOVES_L == 8'd0) ? S_DONE : S_SETUP;
        end
      end
      S_SETUP: w_next_state = bus.abort ? S_IDLE : S_FIRE;
      S_FIRE:  w_next_state = bus.abort ? S_IDLE : S_GAP;
      S_GAP: begin
        if (bus.abort) begin
          w_next_state = S_IDLE;
        end else if (r_gap_cnt == 8'd0) begin
          w_next_state = w_more ? S_SETUP : S_DONE;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    w_busy_d = (w_next_state == S_SETUP) || (w_next_state == S_FIRE) || (w_next_state == S_GAP);
    w_done_d = (w_next_state == S_DONE);
    w_fire_d = (w_next_state == S_FIRE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_lfsr       <= LFSR_INIT;
      r_gap_cnt    <= 8'd0;
      r_moves      <= 8'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_fire       <= 1'b0;
      r_x_nrow     <= 1'b0;
      r_row_column <= 4'b0000;
    end else begin
      r_state <= w_next_state;
      r_lfsr  <= w_lfsr_next;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
      r_fire  <= w_fire_d;

      if (w_next_state == S_SETUP) begin
        r_row_column <= w_move_rc;
        r_x_nrow     <= w_cand_x;
      end else if (!w_busy_d) begin
        r_row_column <= 4'b0000;
        r_x_nrow     <= 1'b0;
      end

      if (w_run_start) begin
        r_moves <= 8'd0;
      end else if (r_state == S_FIRE) begin
        r_moves <= r_moves + 8'd1;
      end

      if (r_state == S_FIRE) begin
        r_gap_cnt <= GAP_LAST;
      end else if ((r_state == S_GAP) && (r_gap_cnt != 8'd0)) begin
        r_gap_cnt <= r_gap_cnt - 8'd1;
      end
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.fire         = r_fire;
  assign bus.row_column   = r_row_column;
  assign bus.x_nRow       = r_x_nrow;
  assign bus.moves_issued = r_moves;
  assign o_state          = r_state;

endmodule

// File: tb/tb_scramble_sequencer.sv
// Bench for scramble_sequencer: four parameterisations share clock and reset, and every run
// is compared cycle by cycle against a schedule and move list derived from the move rules.
module tb_scramble_sequencer;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   rst_p  = 0;

  logic       start_v   [4];
  logic       abort_v   [4];
  logic       obs_busy  [4];
  logic       obs_done  [4];
  logic       obs_fire  [4];
  logic       obs_x     [4];
  logic [3:0] obs_rc    [4];
  logic [7:0] obs_mi    [4];
  logic [2:0] obs_state [4];

  logic [4:0] exp_q[$];
  logic [4:0] obs_log[$];

  scramble_sequencer_if bus [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_tie
    assign bus[g].start  = start_v[g];
    assign bus[g].abort  = abort_v[g];
    assign obs_busy[g]   = bus[g].busy;
    assign obs_done[g]   = bus[g].done;
    assign obs_fire[g]   = bus[g].fire;
    assign obs_x[g]      = bus[g].x_nRow;
    assign obs_rc[g]     = bus[g].row_column;
    assign obs_mi[g]     = bus[g].moves_issued;
  end

  scramble_sequencer #(.MOVES(4),  .GAP(3), .SEED(16'hACE1)) u_dut0 (
    .clk(clk), .reset(reset), .bus(bus[0]), .o_state(obs_state[0]));
  scramble_sequencer #(.MOVES(16), .GAP(3), .SEED(16'h0001)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus[1]), .o_state(obs_state[1]));
  scramble_sequencer #(.MOVES(0),  .GAP(3), .SEED(16'h1234)) u_dut2 (
    .clk(clk), .reset(reset), .bus(bus[2]), .o_state(obs_state[2]));
  scramble_sequencer #(.MOVES(4),  .GAP(2), .SEED(16'h0000)) u_dut3 (
    .clk(clk), .reset(reset), .bus(bus[3]), .o_state(obs_state[3]));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // cyc is the index of the current clock period; rst_p is the period the LFSR holds its seed.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) rst_p <= cyc + 1;
  end

  task automatic apply_reset(input int n);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- reference model ----------------
  function automatic int p_moves(input int i);
    case (i)
      0: return 4;
      1: return 16;
      2: return 0;
      default: return 4;
    endcase
  endfunction

  function automatic int p_gap(input int i);
    return (i == 3) ? 2 : 3;
  endfunction

  function automatic logic [15:0] p_seed(input int i);
    case (i)
      0: return 16'hACE1;
      1: return 16'h0001;
      2: return 16'h1234;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] lfsr_at(input logic [15:0] seed, input int n);
    logic [15:0] v;
    v = (seed == 16'h0000) ? 16'h0001 : seed;
    for (int s = 0; s < n; s++) v = v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    return v;
  endfunction

  // Invariants checked on every cycle for every instance.
  always @(negedge clk) begin
    if (cyc > 0) begin
      for (int g = 0; g < 4; g++) begin
        checks++;
        if (obs_busy[g] && obs_done[g]) begin
          errors++;
          $display("FAIL busy_done_overlap dut%0d cycle %0d: busy=%b done=%b, want never both high",
                   g, cyc, obs_busy[g], obs_done[g]);
        end
        checks++;
        if (obs_fire[g] && !obs_busy[g]) begin
          errors++;
          $display("FAIL fire_without_busy dut%0d cycle %0d: fire=%b busy=%b, want fire only when busy",
                   g, cyc, obs_fire[g], obs_busy[g]);
        end
      end
    end
  end

  // ---------------- driver + scoreboard for one complete run ----------------
  // Raises start in the current period t and checks every cycle up to the IDLE cycle after done.
  task automatic run_full(input int i, input bit hold);
    int t, m, per, done_rel, exp_mi, ln, ln_p;
    logic ax, ax_p, exp_busy, exp_done, exp_fire;
    logic [3:0] onehot;
    logic [15:0] v;
    logic [4:0] cur;
    m = p_moves(i);
    per = p_gap(i) + 2;
    t = cyc;
    done_rel = 1 + m * per;
    exp_q.delete();
    obs_log.delete();
    ax_p = 1'b0;
    ln_p = 0;
    for (int k = 0; k < m; k++) begin
      v = lfsr_at(p_seed(i), t + k * per - rst_p);
      ax = v[2];
      ln = int'(v[1:0]);
      if (k > 0 && ax == ax_p && ln == ln_p) ln = (ln + 1) % 4;
      onehot = 4'b0001 << ln;
      exp_q.push_back({ax, onehot});
      ax_p = ax;
      ln_p = ln;
    end
    cur = 5'b0;
    start_v[i] = 1'b1;
    for (int rel = 1; rel <= done_rel + 1; rel++) begin
      @(negedge clk);
      if (!hold) start_v[i] = 1'b0;
      abort_v[i] = 1'b0;
      exp_busy = (rel <= m * per);
      exp_done = (rel == done_rel);
      exp_fire = (rel >= 2) && (rel < done_rel) && ((rel - 2) % per == 0);
      if (exp_busy && ((rel - 1) % per == 0)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL move_queue dut%0d rel %0d: expected move queue empty, want an entry", i, rel);
        end else begin
          cur = exp_q.pop_front();
        end
      end
      if (!exp_busy) cur = 5'b0;
      checks++;
      if (obs_busy[i] !== exp_busy) begin
        errors++;
        $display("FAIL busy dut%0d rel %0d: got %b want %b", i, rel, obs_busy[i], exp_busy);
      end
      checks++;
      if (obs_done[i] !== exp_done) begin
        errors++;
        $display("FAIL done dut%0d rel %0d: got %b want %b", i, rel, obs_done[i], exp_done);
      end
      checks++;
      if (obs_fire[i] !== exp_fire) begin
        errors++;
        $display("FAIL fire dut%0d rel %0d: got %b want %b", i, rel, obs_fire[i], exp_fire);
      end
      checks++;
      if (obs_rc[i] !== cur[3:0] || obs_x[i] !== cur[4]) begin
        errors++;
        $display("FAIL move dut%0d rel %0d: got x_nRow=%b row_column=%b want x_nRow=%b row_column=%b",
                 i, rel, obs_x[i], obs_rc[i], cur[4], cur[3:0]);
      end
      if (m > 0) begin
        exp_mi = (rel < 3) ? 0 : ((rel - 3) / per + 1);
        if (exp_mi > m) exp_mi = m;
        checks++;
        if (obs_mi[i] !== 8'(exp_mi)) begin
          errors++;
          $display("FAIL moves_issued dut%0d rel %0d: got %0d want %0d", i, rel, obs_mi[i], exp_mi);
        end
      end
      if (obs_fire[i] === 1'b1) obs_log.push_back({obs_x[i], obs_rc[i]});
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    apply_reset(3);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_busy[i] !== 1'b0 || obs_done[i] !== 1'b0 || obs_fire[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_flags dut%0d: got busy=%b done=%b fire=%b want 0 0 0",
                 i, obs_busy[i], obs_done[i], obs_fire[i]);
      end
      checks++;
      if (obs_rc[i] !== 4'b0000 || obs_x[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_move dut%0d: got x_nRow=%b row_column=%b want 0 0000", i, obs_x[i], obs_rc[i]);
      end
      checks++;
      if (obs_mi[i] !== 8'd0) begin
        errors++;
        $display("FAIL reset_moves_issued dut%0d: got %0d want 0", i, obs_mi[i]);
      end
      checks++;
      if (obs_state[i] !== 3'd0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got %0d want 0 (IDLE)", i, obs_state[i]);
      end
    end
  endtask

  task automatic test_normal_run;
    repeat ($urandom_range(0, 6)) @(negedge clk);
    run_full(0, 1'b0);
    checks++;
    if (obs_log.size() != 4) begin
      errors++;
      $display("FAIL normal_fire_count: got %0d want 4", obs_log.size());
    end
    foreach (obs_log[k]) begin
      checks++;
      if ($countones(obs_log[k][3:0]) != 1) begin
        errors++;
        $display("FAIL normal_onehot move %0d: got %b want one-hot", k, obs_log[k][3:0]);
      end
    end
  endtask

  task automatic test_reference_model;
    apply_reset(2);
    run_full(1, 1'b0);
    checks++;
    if (obs_log.size() != 16) begin
      errors++;
      $display("FAIL ref_fire_count: got %0d want 16", obs_log.size());
    end
    for (int k = 1; k < obs_log.size(); k++) begin
      checks++;
      if (obs_log[k] === obs_log[k-1]) begin
        errors++;
        $display("FAIL no_undo move %0d: got %b equal to previous, want different", k, obs_log[k]);
      end
    end
  endtask

  task automatic test_zero_moves;
    repeat (2) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      run_full(2, 1'b0);
      checks++;
      if (obs_log.size() != 0) begin
        errors++;
        $display("FAIL zero_moves_fire: got %0d fires want 0", obs_log.size());
      end
    end
  endtask

  task automatic test_zero_seed;
    int distinct;
    apply_reset(2);
    run_full(3, 1'b0);
    checks++;
    if (obs_log.size() < 1 || obs_log[0] !== 5'b0_0010) begin
      errors++;
      $display("FAIL zero_seed_first_move: got %b want 00010", (obs_log.size() > 0) ? obs_log[0] : 5'bx);
    end
    distinct = 0;
    foreach (obs_log[k]) if (obs_log[k] !== obs_log[0]) distinct++;
    checks++;
    if (distinct == 0) begin
      errors++;
      $display("FAIL zero_seed_varying: got %0d differing moves want at least 1", distinct);
    end
  endtask

  task automatic test_abort;
    int t, a;
    repeat ($urandom_range(0, 5)) @(negedge clk);
    t = cyc;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    a = t + 8 + $urandom_range(0, 2);
    repeat (a - cyc) @(negedge clk);
    checks++;
    if (obs_busy[0] !== 1'b1 || obs_mi[0] !== 8'd2) begin
      errors++;
      $display("FAIL abort_pre: got busy=%b moves_issued=%0d want 1 2", obs_busy[0], obs_mi[0]);
    end
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    checks++;
    if (obs_busy[0] !== 1'b0 || obs_rc[0] !== 4'b0000 || obs_done[0] !== 1'b0 || obs_mi[0] !== 8'd2) begin
      errors++;
      $display("FAIL abort_gap: got busy=%b row_column=%b done=%b moves_issued=%0d want 0 0000 0 2",
               obs_busy[0], obs_rc[0], obs_done[0], obs_mi[0]);
    end
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      checks++;
      if (obs_fire[0] !== 1'b0 || obs_done[0] !== 1'b0 || obs_mi[0] !== 8'd2) begin
        errors++;
        $display("FAIL abort_quiet cycle %0d: got fire=%b done=%b moves_issued=%0d want 0 0 2",
                 c, obs_fire[0], obs_done[0], obs_mi[0]);
      end
    end
    // abort landing on the FIRE cycle: the pulse is already out and is counted
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_fire[0] !== 1'b1) begin
      errors++;
      $display("FAIL abort_fire_pulse: got fire=%b want 1", obs_fire[0]);
    end
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    checks++;
    if (obs_busy[0] !== 1'b0 || obs_fire[0] !== 1'b0 || obs_mi[0] !== 8'd1) begin
      errors++;
      $display("FAIL abort_in_fire: got busy=%b fire=%b moves_issued=%0d want 0 0 1",
               obs_busy[0], obs_fire[0], obs_mi[0]);
    end
    abort_v[0] = 1'b1;
    repeat (3) @(negedge clk);
    abort_v[0] = 1'b0;
    checks++;
    if (obs_busy[0] !== 1'b0 || obs_done[0] !== 1'b0 || obs_mi[0] !== 8'd1) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b done=%b moves_issued=%0d want 0 0 1",
               obs_busy[0], obs_done[0], obs_mi[0]);
    end
  endtask

  task automatic test_start_abort;
    abort_v[0] = 1'b1;
    run_full(0, 1'b0);
  endtask

  task automatic test_held_start;
    run_full(0, 1'b1);
    run_full(0, 1'b0);
  endtask

  task automatic test_reset_mid_run;
    int d, t;
    logic [4:0] log1[$];
    d = $urandom_range(0, 20);
    apply_reset(2);
    repeat (d) @(negedge clk);
    run_full(0, 1'b0);
    log1 = obs_log;
    apply_reset(2);
    repeat (d) @(negedge clk);
    t = cyc;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (t + 12 - cyc) @(negedge clk);
    checks++;
    if (obs_fire[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrun_fire: got fire=%b want 1", obs_fire[0]);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (obs_busy[0] !== 1'b0 || obs_done[0] !== 1'b0 || obs_fire[0] !== 1'b0 ||
        obs_rc[0] !== 4'b0000 || obs_x[0] !== 1'b0 || obs_mi[0] !== 8'd0) begin
      errors++;
      $display("FAIL midrun_reset: got busy=%b done=%b fire=%b row_column=%b x_nRow=%b moves_issued=%0d want all 0",
               obs_busy[0], obs_done[0], obs_fire[0], obs_rc[0], obs_x[0], obs_mi[0]);
    end
    reset = 1'b0;
    repeat (d) @(negedge clk);
    run_full(0, 1'b0);
    checks++;
    if (obs_log.size() != log1.size()) begin
      errors++;
      $display("FAIL replay_count: got %0d want %0d", obs_log.size(), log1.size());
    end else begin
      foreach (log1[k]) begin
        checks++;
        if (obs_log[k] !== log1[k]) begin
          errors++;
          $display("FAIL replay_move %0d: got %b want %b", k, obs_log[k], log1[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(0, 7)) @(negedge clk);
      run_full(($urandom_range(0, 1) == 0) ? 0 : 3, 1'b0);
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      start_v[i] = 1'b0;
      abort_v[i] = 1'b0;
    end
    test_reset();
    test_normal_run();
    test_reference_model();
    test_zero_moves();
    test_zero_seed();
    test_abort();
    test_start_abort();
    test_held_start();
    test_reset_mid_run();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: got no completion by cycle %0d want completion", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scramble_sequencer.md
# scramble_sequencer

Generates the randomized row/column "fire" command stream that scrambles the 4x4 game board. While the top level is in scramble mode, its row/column select mux drives the cell array from this block's outputs. Each move is presented with the same signals a player produces: a one-hot `row_column`, a row/column flag `x_nRow`, and a single-cycle `fire`. A run issues a fixed number of pseudo-random moves, spaced so every cell latches cleanly, and then reports completion.

## Interface
- `MOVES`, default 16: moves issued per run. Legal range 0..255.
- `GAP`, default 15: idle cycles after each `fire` pulse. Legal range 1..255.
- `SEED`, default 16'hACE1: LFSR reset value. A SEED of 0 is replaced by 16'h0001.
- `clk`  in  1  system clock.
- `reset`  in  1  reset reset, synchronous, active-high; clock clk.
- `start`  in  1  begins a run when sampled high in IDLE. Ignored otherwise.
- `abort`  in  1  terminates a run in progress.
- `busy`  out  1  high while a run is in progress.
- `done`  out  1  one-cycle pulse when a run completes normally.
- `fire`  out  1  one-cycle pulse that applies the current move.
- `row_column`  out  4  one-hot line select. 0 when idle.
- `x_nRow`  out  1  0 selects a row, 1 selects a column.
- `moves_issued`  out  8  count of fire pulses issued in the current or last run.

## Operation
- **LFSR**
  - 16-bit Galois LFSR with mask 16'hB400. It shifts right every cycle in every state, so the timing of user presses adds entropy.
  - On reset it loads SEED, or 16'h0001 if SEED is 0.
- **States:** IDLE, SETUP, FIRE, GAP, DONE.
- **IDLE**
  - `busy`=0 and `row_column`=0.
  - On `start`=1: if MOVES=0, go to DONE. Otherwise clear `moves_issued` and go to SETUP.
- **SETUP** (1 cycle)
  - Latch `x_nRow` = lfsr[2] and `row_column` = 1 << lfsr[1:0].
  - No-undo rule: if the candidate (`x_nRow`, `row_column`) equals the previous move of this run, rotate `row_column` left by 1 before latching. The first move of a run is never modified.
  - Then go to FIRE.
- **FIRE** (1 cycle)
  - `fire`=1 and `moves_issued` increments (visible the next cycle).
  - Then go to GAP.
- **GAP** (GAP cycles, counted by an 8-bit down-counter)
  - `row_column` and `x_nRow` are held.
  - On expiry: go to SETUP if `moves_issued` < MOVES, otherwise go to DONE.
- **DONE** (1 cycle)
  - `done`=1, `busy`=0, `row_column`=0. Then go to IDLE.
- **Output stability:** `row_column` and `x_nRow` are held from the SETUP cycle through the last GAP cycle of each move. They therefore never change in the cycle when `fire`=1 or in the cycle on either side of it.
- **abort**
  - In SETUP, FIRE or GAP: the next state is IDLE. No further `fire` pulses, `done` is not pulsed, and `moves_issued` keeps its value.
  - abort in IDLE or DONE has no effect.
  - If abort arrives in the same cycle FIRE is entered, the `fire` pulse of that cycle is still emitted.
- **Simultaneous start and abort in IDLE:** start wins and abort is ignored.
- **Reset mid-run:** the next cycle is IDLE with all outputs at their reset values, and the LFSR is reloaded.

## Timing
- **Reset values:** `busy`=0, `done`=0, `fire`=0, `row_column`=4'b0000, `x_nRow`=0, `moves_issued`=0, state IDLE.
- All outputs are registered, with no combinational path from any input to any output.
- **Latency from `start` sampled in cycle t:**
  - `busy`=1 from t+1.
  - First `fire` at t+2.
  - Move period is GAP+2 cycles, so fire k (k from 0) is at t+2+k*(GAP+2).
  - `done` at t+1+MOVES*(GAP+2), with `busy` low in that same cycle.
  - IDLE the cycle after `done`; a new `start` is accepted from that cycle.
- **MOVES=0:** `done` at t+1, `busy` never rises, and no `fire` is issued.
- `busy` and `done` are never high in the same cycle.
- `fire` is high only while `busy`=1.

## Test plan
- **Normal run:** MOVES=4, GAP=3, `start` pulse at cycle t.
  - `fire` at t+2, t+7, t+12, t+17.
  - `done` at t+21, `busy` high over t+1..t+20.
  - `moves_issued`=4 after the run.
  - `row_column` is one-hot and stable at each `fire`.
- **Reference-model check:** SEED=16'h0001, MOVES=16, `start` on the first cycle after reset.
  - Each (`x_nRow`, `row_column`) matches a cycle-accurate LFSR model including the no-undo rotate.
  - No two consecutive moves are identical.
- **Abort:** assert `abort` during the GAP after the 2nd fire.
  - Next cycle IDLE, `busy`=0, `row_column`=0.
  - No further `fire`, no `done`, and `moves_issued` stays 2.
- **Reset mid-run:** assert `reset` during a FIRE cycle.
  - Next cycle all outputs are 0.
  - A following `start` replays the same move sequence as from power-up, given the same cycle offset.
- **Ignored and zero-length starts:**
  - `start` held high during a whole run does not extend or restart it; a new run begins the cycle after `done` if `start` is still high.
  - With MOVES=0, `start` gives `done` at t+1 and no `fire`.
- **Zero seed:** SEED=0 produces a non-stuck LFSR (value 16'h0001 after reset) and varying moves.
